master_port_router: RTL and testbench

- Master-side port of the parametrised N-slave crossbar. Successor to the fixed 2-slave master port.
- Decodes the master's slave index and drives a one-hot request to the selected slave. Holds that request until the slave-side arbiter grants it.
- Records the target of every accepted request in an in-order ID FIFO. Steers each ack/rdata back to the master using that FIFO, not a fixed delay line.
- Supports multiple outstanding transactions, and returns an error response for out-of-range indices.

---
 rtl/crossbar_pkg.sv | 22 ++
 rtl/xbar_id_fifo.sv | 67 ++++++
 rtl/master_port_router.sv | 162 ++++++++++++++++
 tb/tb_master_port_router.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar master port and its ID FIFO.
// Latency: none (declarations only).
// Backpressure: not applicable.
package crossbar_pkg;

    localparam int          SEL_W_DEF    = 2;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef logic [SEL_W_DEF-1:0] slv_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DECERR
    } state_t;

    // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xbar_id_fifo.sv
// In-order FIFO of target IDs, one entry per accepted master request.
// Latency: push visible at head one cycle later; pop takes effect on the next edge.
// Backpressure: push ignored when full (a same-cycle pop does not free a slot); pop ignored when empty.
module xbar_id_fifo
    import crossbar_pkg::*;
#(
    parameter  int ID_W  = 2,
    parameter  int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic [ID_W-1:0]  head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [ID_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/master_port_router.sv
// Master-side crossbar port: decodes m_sel to a one-hot slave request and steers responses back in order.
// Latency: m_gnt >= 2 cycles after m_req is taken; m_ack 1 cycle after the head slave's s_ack.
// Backpressure: holds s_req until the slave grants; m_stall and no new issue while MAX_OUT are outstanding.
module master_port_router
    import crossbar_pkg::*;
#(
    parameter int                N_SLAVES = 2,
    parameter int                SEL_W    = 2,
    parameter int                DATA_W   = 32,
    parameter int                MAX_OUT  = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_req,
    input  logic [SEL_W-1:0]           m_sel,
    output logic                       m_gnt,
    output logic                       m_stall,
    output logic                       m_ack,
    output logic                       m_err,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [N_SLAVES-1:0]        s_req,
    input  logic [N_SLAVES-1:0]        s_gnt,
    input  logic [N_SLAVES-1:0]        s_ack,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    output logic                       err_sticky
);

    localparam int               CNT_W    = ptr_w(MAX_OUT) + 1;
    localparam logic [SEL_W-1:0] SENTINEL = SEL_W'(N_SLAVES);

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] s_req_q, s_req_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                m_gnt_q, m_gnt_d;
    logic                m_ack_q, m_ack_d;
    logic                m_err_q, m_err_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                err_sticky_q, err_sticky_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SEL_W-1:0]    fifo_push_id, fifo_head;
    logic [CNT_W-1:0]    fifo_count;

    logic [N_SLAVES-1:0] legit_ack, sel_onehot;
    logic [DATA_W-1:0]   head_data;
    logic                head_err, ack_hit;

    xbar_id_fifo #(
        .ID_W  (SEL_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .push_id (fifo_push_id),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Only the slave at the FIFO head may legitimately ack; everything else is stray.
    always_comb begin
        legit_ack  = '0;
        sel_onehot = '0;
        head_data  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (!fifo_empty && fifo_head == SEL_W'(k)) begin
                legit_ack[k] = 1'b1;
                head_data    = s_rdata[k*DATA_W +: DATA_W];
            end
            sel_onehot[k] = (m_sel == SEL_W'(k));
        end
    end

    assign head_err = !fifo_empty && (fifo_head == SENTINEL);
    assign ack_hit  = |(s_ack & legit_ack);
    assign fifo_pop = ack_hit | head_err;

    always_comb begin
        state_d      = state_q;
        s_req_d      = s_req_q;
        sel_d        = sel_q;
        m_gnt_d      = 1'b0;
        fifo_push    = 1'b0;
        fifo_push_id = sel_q;
        unique case (state_q)
            IDLE: begin
                // The m_gnt cycle is dead time: the master may still be holding m_req.
                if (m_req && !m_gnt_q && fifo_count < CNT_W'(MAX_OUT)) begin
                    if (m_sel < SENTINEL) begin
                        s_req_d = sel_onehot;
                        sel_d   = m_sel;
                        state_d = ISSUE;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            ISSUE: begin
                if (|(s_req_q & s_gnt)) begin
                    fifo_push = 1'b1;
                    m_gnt_d   = 1'b1;
                    s_req_d   = '0;
                    state_d   = IDLE;
                end
            end
            DECERR: begin
                fifo_push    = 1'b1;
                fifo_push_id = SENTINEL;
                m_gnt_d      = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ack_d      = fifo_pop;
        m_err_d      = head_err;
        m_rdata_d    = m_rdata_q;
        err_sticky_d = err_sticky_q | (|(s_ack & ~legit_ack));
        if (ack_hit) begin
            m_rdata_d = head_data;
        end else if (head_err) begin
            m_rdata_d = ERR_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s_req_q      <= '0;
            sel_q        <= '0;
            m_gnt_q      <= 1'b0;
            m_ack_q      <= 1'b0;
            m_err_q      <= 1'b0;
            m_rdata_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_req_q      <= s_req_d;
            sel_q        <= sel_d;
            m_gnt_q      <= m_gnt_d;
            m_ack_q      <= m_ack_d;
            m_err_q      <= m_err_d;
            m_rdata_q    <= m_rdata_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign s_req      = s_req_q;
    assign m_gnt      = m_gnt_q;
    assign m_ack      = m_ack_q;
    assign m_err      = m_err_q;
    assign m_rdata    = m_rdata_q;
    assign m_stall    = fifo_full;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_master_port_router.sv
// Bench for master_port_router with three slaves: directed scenarios, then randomized traffic
// checked every cycle against a transaction-queue model of the port.
module tb_master_port_router;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_req = 1'b0;
    logic [SW-1:0] m_sel = '0;
    logic          m_gnt, m_stall, m_ack, m_err, err_sticky;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  s_req;
    logic [N-1:0]  s_gnt = '0;
    logic [N-1:0]  s_ack = '0;
    logic [N*DW-1:0] s_rdata = '0;

    int checks = 0;
    int errors = 0;

    master_port_router #(
        .N_SLAVES (N),
        .SEL_W    (SW),
        .DATA_W   (DW),
        .MAX_OUT  (MO),
        .ERR_DATA (ERR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req      (m_req),
        .m_sel      (m_sel),
        .m_gnt      (m_gnt),
        .m_stall    (m_stall),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .m_rdata    (m_rdata),
        .s_req      (s_req),
        .s_gnt      (s_gnt),
        .s_ack      (s_ack),
        .s_rdata    (s_rdata),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding targets in a queue, plus what the port is currently asking for.
    int          q[$];
    int          mdl_mode = 0;   // 0 free, 1 waiting for slave grant, 2 error reply to push
    int          mdl_tgt  = 0;
    logic        exp_gnt = 1'b0, exp_ack = 1'b0, exp_err = 1'b0, exp_sticky = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [N-1:0] exp_sreq = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int h;
        bit do_pop;
        int push_id;
        logic [N-1:0] legit;
        if (!rst_n) begin
            q.delete();
            mdl_mode   <= 0;
            mdl_tgt    <= 0;
            exp_gnt    <= 1'b0;
            exp_ack    <= 1'b0;
            exp_err    <= 1'b0;
            exp_sticky <= 1'b0;
            exp_rdata  <= '0;
            exp_sreq   <= '0;
        end else begin
            do_pop  = 1'b0;
            push_id = -1;
            legit   = '0;
            exp_ack <= 1'b0;
            exp_err <= 1'b0;
            exp_gnt <= 1'b0;
            if (q.size() != 0) begin
                h = q[0];
                if (h == N) begin
                    do_pop = 1'b1;
                    exp_ack   <= 1'b1;
                    exp_err   <= 1'b1;
                    exp_rdata <= ERR;
                end else begin
                    legit[h] = 1'b1;
                    if (s_ack[h]) begin
                        do_pop = 1'b1;
                        exp_ack   <= 1'b1;
                        exp_rdata <= s_rdata[h*DW +: DW];
                    end
                end
            end
            if ((s_ack & ~legit) != '0) exp_sticky <= 1'b1;
            if (mdl_mode == 1) begin
                if (s_gnt[mdl_tgt]) begin
                    push_id = mdl_tgt;
                    exp_gnt  <= 1'b1;
                    exp_sreq <= '0;
                    mdl_mode <= 0;
                end
            end else if (mdl_mode == 2) begin
                push_id = N;
                exp_gnt  <= 1'b1;
                mdl_mode <= 0;
            end else if (m_req && !exp_gnt && q.size() < MO) begin
                if (int'(m_sel) < N) begin
                    mdl_mode <= 1;
                    mdl_tgt  <= int'(m_sel);
                    exp_sreq <= N'(1) << m_sel;
                end else begin
                    mdl_mode <= 2;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (push_id >= 0) q.push_back(push_id);
        end
    end

    always @(negedge clk) begin : compare
        chk("m_gnt", m_gnt, exp_gnt);
        chk("m_ack", m_ack, exp_ack);
        chk("m_err", m_err, exp_err);
        chk("s_req", s_req, exp_sreq);
        chk("m_stall", m_stall, q.size() == MO);
        chk("err_sticky", err_sticky, exp_sticky);
        if (exp_ack) chk("m_rdata", m_rdata, exp_rdata);
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input int sel);
        int waited;
        m_req  = 1'b1;
        m_sel  = SW'(sel);
        s_gnt  = '1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!m_gnt && waited < 20);
        chk("issue_gnt", m_gnt, 1);
        m_req = 1'b0;
        s_gnt = '0;
    endtask

    task automatic ack(input int k, input logic [31:0] d, input bit expect_resp);
        s_ack = '0;
        s_ack[k] = 1'b1;
        for (int j = 0; j < N; j++) s_rdata[j*DW +: DW] = $urandom;
        s_rdata[k*DW +: DW] = d;
        step();
        s_ack = '0;
        chk("ack_m_ack", m_ack, expect_resp);
        if (expect_resp) chk("ack_m_rdata", m_rdata, d);
    endtask

    initial begin : stim
        int waited;
        step();
        step();
        chk("rst_s_req", s_req, 0);
        chk("rst_m_gnt", m_gnt, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_m_stall", m_stall, 0);
        chk("rst_err_sticky", err_sticky, 0);
        rst_n = 1'b1;
        step();

        // Single read
        m_req = 1'b1;
        m_sel = 2'd1;
        step();
        chk("sr_s_req", s_req, 3'b010);
        s_gnt = 3'b010;
        step();
        chk("sr_m_gnt", m_gnt, 1);
        m_req = 1'b0;
        s_gnt = '0;
        step();
        step();
        ack(1, 32'h1234_5678, 1'b1);
        chk("sr_m_err", m_err, 0);

        // Grant withheld for five cycles; the ack arrives in the m_gnt cycle
        m_req = 1'b1;
        m_sel = 2'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hg_s_req", s_req, 3'b001);
            chk("hg_m_gnt", m_gnt, 0);
            if (i < 4) step();
        end
        s_gnt = 3'b001;
        step();
        chk("hg_m_gnt_after", m_gnt, 1);
        m_req = 1'b0;
        s_gnt = '0;
        ack(0, 32'h0BAD_F00D, 1'b1);

        // Out-of-order ack is stray; in-order acks return in issue order
        issue(1);
        issue(0);
        ack(0, 32'h1111_0000, 1'b0);
        chk("ord_sticky", err_sticky, 1);
        ack(1, 32'hA1A1_0001, 1'b1);
        ack(0, 32'hA0A0_0000, 1'b1);
        issue(1);
        issue(0);
        ack(1, 32'hB1B1_0001, 1'b1);
        ack(0, 32'hB0B0_0000, 1'b1);
        chk("ord_sticky_kept", err_sticky, 1);

        // Full ID FIFO
        issue(0);
        issue(1);
        issue(2);
        issue(0);
        chk("full_stall", m_stall, 1);
        m_req = 1'b1;
        m_sel = 2'd2;
        s_gnt = '1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("full_no_s_req", s_req, 0);
            chk("full_no_gnt", m_gnt, 0);
        end
        ack(0, 32'hC000_0000, 1'b1);
        chk("full_stall_clear", m_stall, 0);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!m_gnt && waited < 10);
        chk("full_fifth_gnt", m_gnt, 1);
        m_req = 1'b0;
        s_gnt = '0;
        ack(1, 32'hC111_1111, 1'b1);
        ack(2, 32'hC222_2222, 1'b1);
        ack(0, 32'hC000_0001, 1'b1);
        ack(2, 32'hC222_2223, 1'b1);

        // Decode error
        m_req = 1'b1;
        m_sel = 2'd3;
        step();
        chk("de_s_req", s_req, 0);
        step();
        chk("de_m_gnt", m_gnt, 1);
        m_req = 1'b0;
        step();
        chk("de_m_ack", m_ack, 1);
        chk("de_m_err", m_err, 1);
        chk("de_m_rdata", m_rdata, 32'hDEAD_BEEF);

        // Asynchronous reset with two transactions outstanding
        issue(0);
        issue(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_s_req", s_req, 0);
        chk("ar_m_gnt", m_gnt, 0);
        chk("ar_m_ack", m_ack, 0);
        chk("ar_m_err", m_err, 0);
        chk("ar_m_rdata", m_rdata, 0);
        chk("ar_m_stall", m_stall, 0);
        chk("ar_err_sticky", err_sticky, 0);
        #1;
        rst_n = 1'b1;
        step();
        ack(0, 32'hE0E0_E0E0, 1'b0);
        chk("ar_stray_sticky", err_sticky, 1);

        // Randomized traffic
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (!m_req || m_gnt) begin
                m_req = ($urandom_range(0, 2) != 0);
                m_sel = SW'($urandom_range(0, 3));
            end
            s_gnt = N'($urandom_range(0, 7));
            for (int j = 0; j < N; j++) s_rdata[j*DW +: DW] = $urandom;
            s_ack = '0;
            if (q.size() != 0 && q[0] < N && $urandom_range(0, 2) == 0) s_ack[q[0]] = 1'b1;
            if ($urandom_range(0, 399) == 0) s_ack[$urandom_range(0, N-1)] = 1'b1;
        end
        m_req = 1'b0;
        for (int i = 0; i < 300 && (q.size() != 0 || mdl_mode != 0); i++) begin
            step();
            s_gnt = '1;
            s_ack = '0;
            if (q.size() != 0 && q[0] < N) s_ack[q[0]] = 1'b1;
        end
        step();
        s_ack = '0;
        s_gnt = '0;
        step();
        chk("drain_empty", q.size(), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
